// File: rtl/rvfpm_result_buffer.sv
// Result buffer between the rvfpm core's CORE-V-XIF result outputs and the host CPU.
// Holds results while the CPU stalls, returns them in arrival order, and silently
// discards any buffered result whose instruction id gets killed by the commit interface.
module rvfpm_result_buffer #(
    parameter int DEPTH       = 4,
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                   ck,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [X_ID_WIDTH-1:0]  in_id,
    input  logic [X_RFW_WIDTH-1:0] in_data,
    input  logic [4:0]             in_rd,
    input  logic                   in_we,
    input  logic [2:0]             in_ecswe,
    input  logic [5:0]             in_ecsdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [X_ID_WIDTH-1:0]  out_id,
    output logic [X_RFW_WIDTH-1:0] out_data,
    output logic [4:0]             out_rd,
    output logic                   out_we,
    output logic [2:0]             out_ecswe,
    output logic [5:0]             out_ecsdata,
    input  logic                   kill_valid,
    input  logic [X_ID_WIDTH-1:0]  kill_id,
    output logic [CW-1:0]          count
);

    logic [X_ID_WIDTH-1:0]  id_q      [DEPTH];
    logic [X_RFW_WIDTH-1:0] data_q    [DEPTH];
    logic [4:0]             rd_q      [DEPTH];
    logic                   we_q      [DEPTH];
    logic [2:0]             ecswe_q   [DEPTH];
    logic [5:0]             ecsdata_q [DEPTH];
    logic [DEPTH-1:0]       live_q;
    logic [PW-1:0]          wr_ptr_q;
    logic [PW-1:0]          rd_ptr_q;
    logic [CW-1:0]          count_q;

    logic occupied;
    logic push;
    logic pop;
    logic drop;
    logic push_live;

    // Handshake and head-disposal decisions, all derived from registered state.
    always_comb begin
        occupied  = (count_q != '0);
        in_ready  = (count_q != CW'(DEPTH));
        out_valid = occupied & live_q[rd_ptr_q];
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        drop      = occupied & ~live_q[rd_ptr_q];
        // A result killed in the very cycle it arrives is stored already dead.
        push_live = ~(kill_valid && (kill_id == in_id));
        out_id      = id_q[rd_ptr_q];
        out_data    = data_q[rd_ptr_q];
        out_rd      = rd_q[rd_ptr_q];
        out_we      = we_q[rd_ptr_q];
        out_ecswe   = ecswe_q[rd_ptr_q];
        out_ecsdata = ecsdata_q[rd_ptr_q];
        count       = count_q;
    end

    // Pointers, occupancy and live bits; later assignments override the kill sweep.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= '0;
        end else begin
            if (kill_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (id_q[i] == kill_id) begin
                        live_q[i] <= 1'b0;
                    end
                end
            end
            if (pop || drop) begin
                live_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q         <= rd_ptr_q + PW'(1);
            end
            if (push) begin
                live_q[wr_ptr_q] <= push_live;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            case ({push, pop | drop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry payload storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i]      <= '0;
                data_q[i]    <= '0;
                rd_q[i]      <= '0;
                we_q[i]      <= 1'b0;
                ecswe_q[i]   <= '0;
                ecsdata_q[i] <= '0;
            end
        end else if (push) begin
            id_q[wr_ptr_q]      <= in_id;
            data_q[wr_ptr_q]    <= in_data;
            rd_q[wr_ptr_q]      <= in_rd;
            we_q[wr_ptr_q]      <= in_we;
            ecswe_q[wr_ptr_q]   <= in_ecswe;
            ecsdata_q[wr_ptr_q] <= in_ecsdata;
        end
    end

endmodule
